// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS core front end.
//   if_state_e : fetch-stage FSM encoding (IDLE, FETCH, HOLD, DRAIN)
//   REDIR_*    : redirect kind codes carried on redir_kind
//   PC_STEP    : byte distance between consecutive instructions
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_DRAIN = 2'b11
    } if_state_e;

    localparam logic [1:0] REDIR_BR  = 2'b00;
    localparam logic [1:0] REDIR_J   = 2'b01;
    localparam logic [1:0] REDIR_JR  = 2'b10;
    localparam logic [1:0] REDIR_EXC = 2'b11;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: bundle of the fetch stage's three buses.
//   imem_*  : level request / one-cycle valid port to instruction memory
//   id_*    : valid/ready handshake carrying the instruction to decode
//   redir_* : redirect request and target operands from execute
// Modports: master = fetch stage side, slave = memory/decode/execute side.
interface ifetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    logic        redir_valid;
    logic [1:0]  redir_kind;
    logic [31:0] redir_pc4;
    logic [31:0] redir_imm;
    logic [25:0] redir_index;
    logic [31:0] redir_reg;

    modport master (
        output imem_req, imem_addr, id_valid, id_inst, id_pc, id_pc4,
        input  imem_rvalid, imem_rdata, id_ready,
        input  redir_valid, redir_kind, redir_pc4, redir_imm, redir_index, redir_reg
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_inst, id_pc, id_pc4,
        output imem_rvalid, imem_rdata, id_ready,
        output redir_valid, redir_kind, redir_pc4, redir_imm, redir_index, redir_reg
    );
endinterface

// File: rtl/ifetch_target.sv
// ifetch_target: combinational redirect target selection.
//   kind/pc4/imm/index/reg_tgt in : redirect operands from execute
//   target out                    : address to load into the PC
//   misaligned out                : target had nonzero low bits (check enabled only)
// Build option IFETCH_ALIGN_CHECK_EN: when defined, a misaligned target is
// replaced by EXC_VECTOR and flagged; otherwise its low two bits are cleared.
module ifetch_target
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic [1:0]  kind,
    input  logic [31:0] pc4,
    input  logic [31:0] imm,
    input  logic [25:0] index,
    input  logic [31:0] reg_tgt,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] raw;

    always_comb begin
        raw = EXC_VECTOR;
        unique case (kind)
            // imm << 2 keeps only imm[29:0], which is the word offset modulo 2^32
            REDIR_BR:  raw = pc4 + (imm << 2);
            REDIR_J:   raw = {pc4[31:28], index, 2'b00};
            REDIR_JR:  raw = reg_tgt;
            REDIR_EXC: raw = EXC_VECTOR;
            default:   raw = EXC_VECTOR;
        endcase
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misaligned = (raw[1:0] != 2'b00);
    assign target     = misaligned ? EXC_VECTOR : raw;
`else
    assign misaligned = 1'b0;
    assign target     = raw & ~32'h0000_0003;
`endif

endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction fetch stage of the 32-instruction MIPS core.
//   clk, reset (async, active-high)
//   bus (ifetch_if.master): imem request/response, decode handshake, redirects
//   align_err out: sticky misaligned-target flag (always 0 unless the
//                  IFETCH_ALIGN_CHECK_EN build option is defined)
// One request outstanding at most; a redirect that arrives while a request is
// in flight parks the FSM in DRAIN until the stale response has been dropped.
module ifetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_if.master      bus,
    output logic          align_err
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        align_err_q, align_err_d;

    logic [31:0] target;
    logic        misaligned;

    ifetch_target #(.EXC_VECTOR(EXC_VECTOR)) u_target (
        .kind       (bus.redir_kind),
        .pc4        (bus.redir_pc4),
        .imm        (bus.redir_imm),
        .index      (bus.redir_index),
        .reg_tgt    (bus.redir_reg),
        .target     (target),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= 32'h0;
            id_inst_q    <= 32'h0;
            id_pc_q      <= 32'h0;
            id_pc4_q     <= PC_STEP;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            id_inst_q    <= id_inst_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
            align_err_q  <= align_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        id_inst_d    = id_inst_q;
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;
        align_err_d  = align_err_q;

        if (bus.redir_valid) begin
            // Redirect beats every other event, including a HOLD handshake.
            pc_d        = target;
            align_err_d = align_err_q | misaligned;
            unique case (state_q)
                ST_IDLE, ST_HOLD: begin
                    state_d      = ST_FETCH;
                    fetch_addr_d = target;
                end
                ST_FETCH, ST_DRAIN: begin
                    // Response in hand: drop it and refetch now; otherwise wait
                    // in DRAIN for the stale response before reissuing.
                    if (bus.imem_rvalid) begin
                        state_d      = ST_FETCH;
                        fetch_addr_d = target;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d      = ST_FETCH;
                    fetch_addr_d = pc_q;
                end
                ST_FETCH: begin
                    if (bus.imem_rvalid) begin
                        id_inst_d = bus.imem_rdata;
                        id_pc_d   = fetch_addr_q;
                        id_pc4_d  = fetch_addr_q + PC_STEP;
                        pc_d      = fetch_addr_q + PC_STEP;
                        state_d   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.id_ready) begin
                        state_d      = ST_FETCH;
                        fetch_addr_d = pc_q;
                    end
                end
                ST_DRAIN: begin
                    if (bus.imem_rvalid) begin
                        state_d      = ST_FETCH;
                        fetch_addr_d = pc_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign bus.imem_addr = fetch_addr_q;
    assign bus.id_valid  = (state_q == ST_HOLD);
    assign bus.id_inst   = id_inst_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_pc4    = id_pc4_q;
    assign align_err     = align_err_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: directed test of ifetch_stage with hand-computed expectations.
// The memory model answers either in the same cycle as the request (mem_auto)
// or only when mem_drv is raised; data is a fixed function of the address.
module tb_ifetch_stage;
    import mips_pkg::*;

    logic clk;
    logic reset;
    logic align_err;
    logic mem_auto;
    logic mem_drv;

    int checks = 0;
    int errors = 0;

    ifetch_if bus();

    ifetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .align_err (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return {16'hA5A5, a[15:0]};
    endfunction

    assign bus.imem_rvalid = mem_auto ? bus.imem_req : mem_drv;
    assign bus.imem_rdata  = mem_word(bus.imem_addr);

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [1:0] kind, input logic [31:0] pc4, input logic [31:0] imm,
                            input logic [25:0] idx, input logic [31:0] rg);
        bus.redir_valid = 1'b1;
        bus.redir_kind  = kind;
        bus.redir_pc4   = pc4;
        bus.redir_imm   = imm;
        bus.redir_index = idx;
        bus.redir_reg   = rg;
    endtask

    initial begin
        reset = 1'b1;
        mem_auto = 1'b0;
        mem_drv = 1'b0;
        bus.id_ready = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_kind = 2'b00;
        bus.redir_pc4 = 32'h0;
        bus.redir_imm = 32'h0;
        bus.redir_index = 26'h0;
        bus.redir_reg = 32'h0;

        tick(); tick();
        check_val("rst_id_valid", {31'h0, bus.id_valid}, 32'h0);
        check_val("rst_id_inst", bus.id_inst, 32'h0);
        check_val("rst_id_pc", bus.id_pc, 32'h0);
        check_val("rst_id_pc4", bus.id_pc4, 32'h4);
        check_val("rst_req", {31'h0, bus.imem_req}, 32'h0);
        check_val("rst_align", {31'h0, align_err}, 32'h0);

        // Zero-wait memory from reset release
        reset = 1'b0;
        mem_auto = 1'b1;
        tick();
        check_val("c1_req", {31'h0, bus.imem_req}, 32'h1);
        check_val("c1_addr", bus.imem_addr, 32'h0);
        tick();
        check_val("c2_valid", {31'h0, bus.id_valid}, 32'h1);
        check_val("c2_inst", bus.id_inst, 32'h2008_0005);
        check_val("c2_pc", bus.id_pc, 32'h0);
        check_val("c2_pc4", bus.id_pc4, 32'h4);

        // Decode stalls for five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("stall_valid", {31'h0, bus.id_valid}, 32'h1);
            check_val("stall_inst", bus.id_inst, 32'h2008_0005);
            check_val("stall_pc", bus.id_pc, 32'h0);
            check_val("stall_req", {31'h0, bus.imem_req}, 32'h0);
        end

        bus.id_ready = 1'b1;
        tick();
        bus.id_ready = 1'b0;
        check_val("seq_addr", bus.imem_addr, 32'h4);
        check_val("seq_req", {31'h0, bus.imem_req}, 32'h1);
        tick();
        check_val("seq_inst", bus.id_inst, 32'hA5A5_0004);
        check_val("seq_pc", bus.id_pc, 32'h4);
        check_val("seq_pc4", bus.id_pc4, 32'h8);

        // Branch in HOLD: 0x10 + (-2 << 2) = 0x08
        redirect(REDIR_BR, 32'h10, 32'hFFFF_FFFE, 26'h0, 32'h0);
        mem_auto = 1'b0;
        tick();
        bus.redir_valid = 1'b0;
        check_val("br_valid", {31'h0, bus.id_valid}, 32'h0);
        check_val("br_addr", bus.imem_addr, 32'h8);

        // jr to 0x40 while the request to 0x08 is in flight
        redirect(REDIR_JR, 32'h0, 32'h0, 26'h0, 32'h40);
        tick();
        bus.redir_valid = 1'b0;
        check_val("drain_addr0", bus.imem_addr, 32'h8);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("drain_addr", bus.imem_addr, 32'h8);
            check_val("drain_req", {31'h0, bus.imem_req}, 32'h1);
            check_val("drain_valid", {31'h0, bus.id_valid}, 32'h0);
        end
        mem_drv = 1'b1;
        tick();
        mem_drv = 1'b0;
        check_val("post_drain_addr", bus.imem_addr, 32'h40);
        check_val("post_drain_valid", {31'h0, bus.id_valid}, 32'h0);
        mem_auto = 1'b1;
        tick();
        mem_auto = 1'b0;
        check_val("tgt_pc", bus.id_pc, 32'h40);
        check_val("tgt_inst", bus.id_inst, 32'hA5A5_0040);

        // Misaligned jr from HOLD
        redirect(REDIR_JR, 32'h0, 32'h0, 26'h0, 32'h0000_0102);
        tick();
        bus.redir_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        check_val("align_addr", bus.imem_addr, 32'h180);
        check_val("align_flag", {31'h0, align_err}, 32'h1);
`else
        check_val("align_addr", bus.imem_addr, 32'h100);
        check_val("align_flag", {31'h0, align_err}, 32'h0);
`endif

        // Jump while FETCH is waiting, then reset in DRAIN
        redirect(REDIR_J, 32'h3000_0010, 32'h0, 26'h000_0020, 32'h0);
        tick();
        bus.redir_valid = 1'b0;
        check_val("j_drain_req", {31'h0, bus.imem_req}, 32'h1);
        reset = 1'b1;
        #1;
        check_val("arst_req", {31'h0, bus.imem_req}, 32'h0);
        check_val("arst_valid", {31'h0, bus.id_valid}, 32'h0);
        check_val("arst_addr", bus.imem_addr, 32'h0);
        check_val("arst_align", {31'h0, align_err}, 32'h0);
        mem_drv = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        mem_drv = 1'b0;
        check_val("restart_addr", bus.imem_addr, 32'h0);
        check_val("restart_valid", {31'h0, bus.id_valid}, 32'h0);
        mem_auto = 1'b1;
        tick();
        check_val("restart_pc", bus.id_pc, 32'h0);
        check_val("restart_inst", bus.id_inst, 32'h2008_0005);

        // Exception redirect together with a handshake: flush wins
        bus.id_ready = 1'b1;
        redirect(REDIR_EXC, 32'h0, 32'h0, 26'h0, 32'h0);
        mem_auto = 1'b0;
        tick();
        bus.redir_valid = 1'b0;
        bus.id_ready = 1'b0;
        check_val("exc_addr", bus.imem_addr, 32'h180);
        check_val("exc_valid", {31'h0, bus.id_valid}, 32'h0);
        mem_auto = 1'b1;
        tick();
        mem_auto = 1'b0;
        check_val("exc_pc", bus.id_pc, 32'h180);
        check_val("exc_pc4", bus.id_pc4, 32'h184);

        // Jump from HOLD: {0x3, 0x20, 00} = 0x3000_0080
        redirect(REDIR_J, 32'h3000_0010, 32'h0, 26'h000_0020, 32'h0);
        tick();
        bus.redir_valid = 1'b0;
        check_val("j_addr", bus.imem_addr, 32'h3000_0080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction fetch stage of the 32-instruction MIPS core. It holds the PC and fetches one word at a time from instruction memory over a level request/valid port. It presents each instruction to decode through a valid/ready handshake; decode passes inst[15:0] on to the sign extender. It takes redirects (branch, jump, jr, exception) from execute and computes targets from the sign-extended immediate that execute returns.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset
- EXC_VECTOR, 32'h0000_0180, target for redirect kind 2'b11 and for alignment faults
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_req  out  1  fetch request, level; high until imem_rvalid
- imem_addr  out  32  fetch address, stable while imem_req
- imem_rvalid  in  1  one-cycle response strobe; may assert in the same cycle as imem_req
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- id_valid  out  1  id_inst/id_pc valid
- id_ready  in  1  decode accepts
- id_inst  out  32  instruction
- id_pc  out  32  address of id_inst
- id_pc4  out  32  id_pc + 4
- redir_valid  in  1  redirect this cycle
- redir_kind  in  2  00 branch, 01 j/jal, 10 jr/jalr, 11 exception
- redir_pc4  in  32  PC+4 of the redirecting instruction
- redir_imm  in  32  sign-extended 16-bit immediate
- redir_index  in  26  jump index field
- redir_reg  in  32  register target
- align_err  out  1  sticky misaligned-target flag

## Operation
- States: IDLE, FETCH, HOLD, DRAIN. Registers: pc (next fetch address), fetch_addr (address of the outstanding request).
- Reset values: state=IDLE, pc=RESET_PC, fetch_addr=0, id_valid=0, id_inst=0, id_pc=0, id_pc4=4, imem_req=0, align_err=0.
- IDLE -> FETCH unconditionally. On entry to FETCH, fetch_addr<=pc.
- Outputs by state:
  - imem_req=1 in FETCH and DRAIN.
  - imem_addr=fetch_addr.
  - id_valid=1 only in HOLD.
- FETCH, imem_rvalid=1: id_inst<=imem_rdata, id_pc<=fetch_addr, pc<=fetch_addr+4, next state HOLD.
- HOLD, id_ready=1: next state FETCH. Otherwise outputs hold unchanged.
- Redirect targets (32-bit, wrap modulo 2^32):
  - branch: redir_pc4 + {redir_imm[29:0],2'b00}
  - jump: {redir_pc4[31:28], redir_index, 2'b00}
  - jr: redir_reg
  - exception: EXC_VECTOR
- Redirect has priority over all other events and always sets pc<=target:
  - IDLE: next state FETCH.
  - FETCH with imem_rvalid: response discarded, next state FETCH.
  - FETCH without imem_rvalid: next state DRAIN, fetch_addr unchanged.
  - HOLD: held instruction flushed, next state FETCH.
  - DRAIN: stay in DRAIN, pc overwritten (last redirect wins).
- DRAIN, imem_rvalid=1: data discarded, next state FETCH.
- Redirect in the same cycle as a HOLD handshake: the flush wins. Decode must qualify acceptance with !redir_valid.
- No overlapping requests: at most one outstanding.

## Timing
- Zero-wait memory: FETCH (rvalid) -> HOLD -> FETCH; one instruction per 2 cycles peak.
- Latency from redirect to new imem_addr: 1 cycle (FETCH/HOLD/IDLE). From DRAIN, 1 cycle after the stale rvalid.
- Reset asserted mid-request: all state returns to reset values immediately; any later imem_rvalid seen in IDLE is ignored.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined:
  - A target with [1:0]!=0 loads pc=EXC_VECTOR instead of the target.
  - align_err is set and stays 1 until reset.
- IFETCH_ALIGN_CHECK_EN undefined:
  - Target bits [1:0] are forced to 00.
  - align_err is tied 0.

## Structure
- Shared package mips_pkg holds:
  - the state encoding;
  - REDIR_BR/REDIR_J/REDIR_JR/REDIR_EXC constants;
  - PC_STEP=4.
- Sub-module ifetch_target: combinational target mux from redir_kind/pc4/imm/index/reg, plus the alignment check.

## Test plan
- Reset release, memory returns 32'h2008_0005 same cycle: imem_addr=0 in cycle 1; id_valid=1, id_inst=32'h2008_0005, id_pc=0 next cycle; the fetch after that uses addr 4.
- id_ready low for 5 cycles in HOLD: id_inst/id_pc stable, imem_req=0 throughout.
- Branch redirect in HOLD with redir_pc4=32'h10, redir_imm=32'hFFFF_FFFE: id_valid drops; next imem_addr=32'h08.
- Redirect to 32'h40 in FETCH, rvalid delayed 3 cycles: imem_addr stays old until the stale rvalid, data discarded, next request at 32'h40, never presented at old address.
- jr to 32'h0000_0102 with IFETCH_ALIGN_CHECK_EN: align_err=1, next imem_addr=32'h180. Without the macro: next addr=32'h100, align_err=0.
- Reset asserted during DRAIN: immediate IDLE, id_valid=0; fetch restarts at RESET_PC.
